// File: rtl/adc_frame_buffer.sv
// adc_frame_buffer
//   Takes 12-bit offset-binary ADC samples, centres them to signed, optionally
//   applies first-order pre-emphasis, and stores them in a circular buffer of
//   2*FRAME_LEN entries. Overlapping frames of FRAME_LEN samples, one every HOP
//   samples, are streamed out oldest-first on a valid/ready interface.
//
//   Build option: define ADC_FRAME_PREEMPH_EN to enable pre-emphasis
//   y = c - c_prev + (c_prev >>> 5); otherwise y = c.
//
//   Ports
//     clk, rst    : clock, asynchronous active-high reset
//     adc_data    : 12-bit unsigned ADC sample
//     adc_valid   : one-cycle strobe qualifying adc_data
//     out_data    : signed OUT_W processed sample
//     out_valid   : out_data valid
//     out_ready   : consumer accepts on out_valid && out_ready
//     out_last    : marks the FRAME_LEN-th sample of a frame
//     frame_idx   : index of the frame on the output, wraps at 16 bits
//     overflow    : sticky error (dropped trigger or overwritten frame)
module adc_frame_buffer #(
    parameter int FRAME_LEN = 256,
    parameter int HOP       = 128,
    parameter int OUT_W     = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [11:0]             adc_data,
    input  logic                    adc_valid,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last,
    output logic [15:0]             frame_idx,
    output logic                    overflow
);

    localparam int DEPTH = 2 * FRAME_LEN;
    localparam int AW    = $clog2(DEPTH);

    typedef enum logic [1:0] {FILL, STREAM, IDLE} state_t;

    function automatic logic signed [12:0] centre(input logic [11:0] d);
        return $signed({1'b0, d} - 13'd2048);
    endfunction

    function automatic logic signed [OUT_W-1:0] sext13(input logic signed [12:0] v);
        return {{(OUT_W-13){v[12]}}, v};
    endfunction

`ifdef ADC_FRAME_PREEMPH_EN
    function automatic logic signed [OUT_W-1:0] preemph(input logic signed [12:0] c,
                                                        input logic signed [12:0] cp);
        logic signed [OUT_W-1:0] ce;
        logic signed [OUT_W-1:0] pe;
        ce = sext13(c);
        pe = sext13(cp);
        return ce - pe + (pe >>> 5);
    endfunction
`endif

    // ---- stage p0: centring / pre-emphasis on the adc_valid cycle ----
    logic signed [12:0]      c_p0;
    logic signed [OUT_W-1:0] y_p0;

    assign c_p0 = centre(adc_data);

`ifdef ADC_FRAME_PREEMPH_EN
    logic signed [12:0] c_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_prev <= '0;
        end else if (adc_valid) begin
            c_prev <= c_p0;
        end
    end

    assign y_p0 = preemph(c_p0, c_prev);
`else
    assign y_p0 = sext13(c_p0);
`endif

    // ---- stage p1: registered sample, written to the buffer next edge ----
    logic signed [OUT_W-1:0] y_p1;
    logic                    vld_p1;
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           wr_ptr_nx;
    logic                    filled;
    logic                    trig;
    logic [AW-1:0]           trig_start;

    always_ff @(posedge clk) begin
        if (adc_valid) begin
            y_p1 <= y_p0;
        end
    end

    assign wr_ptr_nx  = wr_ptr + AW'(1);
    // Fires on the FRAME_LEN-th write and every HOP writes after it; HOP divides
    // FRAME_LEN so the pointer alignment identifies hop boundaries.
    assign trig       = vld_p1 && (filled || (wr_ptr_nx == AW'(FRAME_LEN)))
                        && ((wr_ptr_nx & AW'(HOP-1)) == '0);
    assign trig_start = wr_ptr_nx - AW'(FRAME_LEN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            wr_ptr <= '0;
            filled <= 1'b0;
        end else begin
            vld_p1 <= adc_valid;
            if (vld_p1) begin
                wr_ptr <= wr_ptr_nx;
                if (wr_ptr_nx == AW'(FRAME_LEN)) begin
                    filled <= 1'b1;
                end
            end
        end
    end

    // ---- buffer: write port from p1, synchronous read port ----
    logic signed [OUT_W-1:0] mem [DEPTH];
    logic signed [OUT_W-1:0] ram_q;
    logic                    rd_en;
    logic [AW-1:0]           rd_addr;

    always_ff @(posedge clk) begin
        if (vld_p1) begin
            mem[wr_ptr] <= y_p1;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_en) begin
            ram_q <= mem[rd_addr];
        end
    end

    // ---- frame control FSM ----
    state_t        state;
    state_t        state_nx;
    logic [AW-1:0] rd_base;
    logic [AW-1:0] rd_cnt;
    logic          pend;
    logic          pend_nx;
    logic [AW-1:0] pend_start;
    logic [AW-1:0] pend_start_nx;
    logic          load;
    logic [AW-1:0] load_start;
    logic          drop;
    logic          hazard;
    logic          pop;
    logic          last_hs;
    logic          rd_vld_p1;
    logic          rd_last_p1;
    logic          skid_vld;
    logic          skid_last;
    logic signed [OUT_W-1:0] skid_data;
    logic [1:0]    occ_nx;

    assign pop     = out_valid && out_ready;
    assign last_hs = pop && out_last;

    always_comb begin
        state_nx      = state;
        load          = 1'b0;
        load_start    = trig_start;
        pend_nx       = pend;
        pend_start_nx = pend_start;
        drop          = 1'b0;
        case (state)
            FILL, IDLE: begin
                if (trig) begin
                    state_nx = STREAM;
                    load     = 1'b1;
                end
            end
            STREAM: begin
                if (last_hs) begin
                    if (pend) begin
                        // pending frame starts now; a coincident trigger takes its slot
                        load          = 1'b1;
                        load_start    = pend_start;
                        pend_nx       = trig;
                        pend_start_nx = trig_start;
                    end else if (trig) begin
                        load = 1'b1;
                    end else begin
                        state_nx = IDLE;
                    end
                end else if (trig) begin
                    if (pend) begin
                        drop = 1'b1;
                    end else begin
                        pend_nx       = 1'b1;
                        pend_start_nx = trig_start;
                    end
                end
            end
            default: state_nx = FILL;
        endcase
    end

    // After FRAME_LEN writes since the frame's trigger the write pointer has
    // come back round to the frame's start address.
    assign hazard = (state == STREAM) && vld_p1 && (wr_ptr_nx == rd_base) && !last_hs;

    // Entries held after this edge (output + skid + read landing now). A new
    // read is only issued when it is guaranteed a slot when it lands.
    assign occ_nx  = 2'(out_valid) + 2'(skid_vld) + 2'(rd_vld_p1) - 2'(pop);
    assign rd_en   = (state == STREAM) && (rd_cnt != AW'(FRAME_LEN)) && (occ_nx <= 2'd1);
    assign rd_addr = rd_base + rd_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= FILL;
            rd_base    <= '0;
            rd_cnt     <= '0;
            pend       <= 1'b0;
            pend_start <= '0;
            overflow   <= 1'b0;
            frame_idx  <= '0;
            rd_vld_p1  <= 1'b0;
            rd_last_p1 <= 1'b0;
        end else begin
            state      <= state_nx;
            pend       <= pend_nx;
            pend_start <= pend_start_nx;
            if (load) begin
                rd_base <= load_start;
                rd_cnt  <= '0;
            end else if (rd_en) begin
                rd_cnt <= rd_cnt + AW'(1);
            end
            if (drop || hazard) begin
                overflow <= 1'b1;
            end
            if (last_hs) begin
                frame_idx <= frame_idx + 16'd1;
            end
            rd_vld_p1  <= rd_en;
            rd_last_p1 <= rd_en && (rd_cnt == AW'(FRAME_LEN-1));
        end
    end

    // ---- stage p2: output register with one skid slot ----
    always_ff @(posedge clk) begin
        if (rd_vld_p1 && ((out_valid && !out_ready) || skid_vld)) begin
            skid_data <= ram_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            skid_vld  <= 1'b0;
            skid_last <= 1'b0;
        end else if (out_valid && !out_ready) begin
            if (rd_vld_p1) begin
                skid_vld  <= 1'b1;
                skid_last <= rd_last_p1;
            end
        end else if (skid_vld) begin
            out_valid <= 1'b1;
            out_data  <= skid_data;
            out_last  <= skid_last;
            skid_vld  <= rd_vld_p1;
            skid_last <= rd_last_p1;
        end else begin
            out_valid <= rd_vld_p1;
            out_last  <= rd_vld_p1 && rd_last_p1;
            if (rd_vld_p1) begin
                out_data <= ram_q;
            end
        end
    end

endmodule
